shift_load_sequencer: RTL and testbench
=======================================

Name: shift_load_sequencer

Overview:
Upstream control stage for the 4-bit right-shift register. It accepts parallel words over a valid/ready handshake and buffers them in a small FIFO. For each word it issues one `load` pulse with the word on `d`, then WIDTH evenly spaced `shift_en` pulses, so the register's LSB serialises the word out. It pulses `word_done` on the last shift and chains buffered words back-to-back with no idle gap.

Parameters:
- WIDTH, 4: word width; equals the downstream register width and the number of shifts per word.
- FIFO_DEPTH, 4: input buffer depth in words; power of 2, ≥2.
- DIV, 1: cycles between successive `shift_en` pulses; ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  upstream word valid
- in_data  in  WIDTH  upstream word
- in_ready  out  1  FIFO can accept a word
- load  out  1  to register `load`; one-cycle pulse
- d  out  WIDTH  to register `d`; word being loaded
- shift_en  out  1  to register `shift_en`; one-cycle pulse
- busy  out  1  a word is in LOAD or SHIFT
- word_done  out  1  one-cycle pulse on the final shift of a word
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently buffered

Behaviour:
- Interface: reset `rst`, synchronous, active-high; clock `clk`. All state updates on posedge clk.
- Reset values: `load`=0, `shift_en`=0, `word_done`=0, `busy`=0, `d`=0, `fifo_count`=0, `in_ready`=1, state=IDLE. Reset flushes the FIFO.
- All outputs are driven from flops or from a decode of registered state only; no input→output combinational path.
- Handshake:
  - Push occurs when in_valid && in_ready.
  - in_ready = (fifo_count < FIFO_DEPTH).
  - No bypass: a pushed word is poppable the cycle after the push.
- FIFO count rules:
  - Push and pop in the same cycle leave the count unchanged.
  - When full, push is blocked via in_ready=0, even if a pop occurs in the same cycle.
- States:
  - IDLE: if the FIFO is non-empty, pop the head into the `d` register and go to LOAD; otherwise stay.
  - LOAD: drive `load`=1 for exactly one cycle. Clear div_cnt and bit_cnt. Go to SHIFT.
  - SHIFT:
    - div_cnt increments each cycle.
    - When div_cnt==DIV-1: `shift_en`=1 that cycle, div_cnt←0, bit_cnt←bit_cnt+1.
    - On the shift with bit_cnt==WIDTH-1: `word_done`=1 in the same cycle.
    - After that shift, if the FIFO is non-empty: pop into `d` and go to LOAD (back-to-back).
    - Otherwise go to IDLE.
- Timing:
  - First word from IDLE: word present in FIFO at cycle N → `load` at N+1 → shifts at N+1+k·DIV for k=1..WIDTH.
  - Back-to-back words: `load` immediately follows the previous word's final `shift_en` cycle.
- Invariants:
  - `load` and `shift_en` are never high in the same cycle.
  - Exactly WIDTH `shift_en` pulses occur per `load`.
  - `d` holds its value from the `load` cycle until the next pop.
  - busy = (state != IDLE).
- Reset mid-operation: the current word is abandoned with no `word_done`, FIFO contents are lost, and `load`/`shift_en` are low from the next cycle.
- `in_valid` high while in_ready=0 is ignored; the upstream source must hold its data.

Decomposition:
- Package `shift_seq_pkg`:
  - state enum {IDLE, LOAD, SHIFT}
  - localparam DEFAULT_WIDTH=4
  - helper for counter widths ($clog2 of DIV and WIDTH)
- Sub-module `sync_fifo`, parameterised by WIDTH and DEPTH:
  - ports: push, pop, wdata, rdata, count, full, empty
  - pointers wrap modulo DEPTH
  - count is the registered occupancy

Test Plan:
- Single word, DIV=1: push 4'b1011 at cycle 0 → `load` at cycle 2 with d=4'b1011; `shift_en` at cycles 3,4,5,6; `word_done` at 6. Downstream q sequence: 1011, 0101, 0010, 0001, 0000. Serial LSB out: 1,1,0,1.
- DIV=3: single word → `shift_en` exactly every 3 cycles, 4 pulses, `busy` low the cycle after `word_done`.
- Back-to-back: push 4'hA, 4'h5, 4'hF consecutively → three `load` pulses, each immediately following the previous word's `word_done` cycle; 12 total `shift_en` pulses; `load`/`shift_en` never overlap.
- Backpressure: hold in_valid with no draining possible (5 pushes, FIFO_DEPTH=4) → in_ready=0 once count=4; the 5th word is accepted only after the first pop; no word lost or duplicated.
- Simultaneous push and pop at count=3: count stays 3 and data order is preserved.
- Reset during SHIFT after 2 shifts, with 2 words queued → `fifo_count`=0 and `in_ready`=1 the next cycle; no further `shift_en`/`word_done`; a new push then runs normally.

Source files
------------

// File: rtl/shift_load_sequencer_pkg.sv
// Shared types and sizing helpers for the shift/load sequencer.
// Imported by the sequencer top and its interface users.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

  // A counter for n values needs at least one bit, even when n == 1.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_load_sequencer_if.sv
// Upstream word handshake plus downstream shift-register controls.
// The master drives words in; the slave (the sequencer) drives everything else.
interface shift_load_sequencer_if #(
  parameter int WIDTH      = 4,
  parameter int FIFO_DEPTH = 4
);
  logic                          in_valid;
  logic [WIDTH-1:0]              in_data;
  logic                          in_ready;
  logic                          load;
  logic [WIDTH-1:0]              d;
  logic                          shift_en;
  logic                          busy;
  logic                          word_done;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport master (
    output in_valid, in_data,
    input  in_ready, load, d, shift_en, busy, word_done, fifo_count
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, load, d, shift_en, busy, word_done, fifo_count
  );
endinterface

// File: rtl/shift_load_sequencer_fifo.sv
// Small synchronous FIFO with registered occupancy; no read bypass.
// Push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/shift_load_sequencer.sv
// Buffers parallel words and drives load + WIDTH spaced shift pulses per word
// into a downstream right-shift register; outputs decode registered state only.
module shift_load_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV        = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  shift_load_sequencer_if.slave  bus
);
  localparam int DW = cnt_w(DIV);
  localparam int BW = cnt_w(WIDTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e           state_q, state_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] d_q, d_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic [CW-1:0]    fifo_count;
  logic             shift_fire, last_shift;

  assign fifo_push = bus.in_valid && !fifo_full;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (bus.in_data),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign shift_fire = (state_q == SHIFT) && (div_cnt_q == DW'(DIV - 1));
  assign last_shift = shift_fire && (bit_cnt_q == BW'(WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    d_d       = d_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          d_d      = fifo_rdata;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        div_cnt_d = '0;
        bit_cnt_d = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        div_cnt_d = div_cnt_q + DW'(1);
        if (shift_fire) begin
          div_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + BW'(1);
          // Chain the next word straight after the final shift.
          if (last_shift) begin
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              d_d      = fifo_rdata;
              state_d  = LOAD;
            end else begin
              state_d  = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      d_q       <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      d_q       <= d_d;
    end
  end

  assign bus.in_ready   = !fifo_full;
  assign bus.load       = (state_q == LOAD);
  assign bus.d          = d_q;
  assign bus.shift_en   = shift_fire;
  assign bus.word_done  = last_shift;
  assign bus.busy       = (state_q != IDLE);
  assign bus.fifo_count = fifo_count;

endmodule

// File: tb/tb_shift_load_sequencer.sv
// Directed bench for shift_load_sequencer: one DUT with DIV=1, one with DIV=3.
module tb_shift_load_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  shift_load_sequencer_if #(.WIDTH(4), .FIFO_DEPTH(4)) b1 ();
  shift_load_sequencer_if #(.WIDTH(4), .FIFO_DEPTH(4)) b3 ();

  shift_load_sequencer #(.WIDTH(4), .FIFO_DEPTH(4), .DIV(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave));
  shift_load_sequencer #(.WIDTH(4), .FIFO_DEPTH(4), .DIV(3)) u3 (
    .clk(clk), .rst(rst), .bus(b3.slave));

  // Downstream 4-bit right-shift register fed by u1.
  logic [3:0] q1;
  always @(posedge clk) begin
    if (b1.load) q1 <= b1.d;
    else if (b1.shift_en) q1 <= {1'b0, q1[3:1]};
  end

  logic [3:0] loads1 [$];
  logic [3:0] loads3 [$];
  int shifts1 = 0, dones1 = 0, overlaps1 = 0;
  int shifts3 = 0, dones3 = 0, overlaps3 = 0;

  always @(negedge clk) begin
    if (b1.load) loads1.push_back(b1.d);
    if (b1.shift_en) shifts1++;
    if (b1.word_done) dones1++;
    if (b1.load && b1.shift_en) overlaps1++;
    if (b3.load) loads3.push_back(b3.d);
    if (b3.shift_en) shifts3++;
    if (b3.word_done) dones3++;
    if (b3.load && b3.shift_en) overlaps3++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b1.in_valid = 1'b0; b1.in_data = '0;
    b3.in_valid = 1'b0; b3.in_data = '0;
    step(); step();
    checks++;
    if ({b1.load, b1.shift_en, b1.word_done, b1.busy, b1.in_ready} !== 5'b00001)
      $display("FAIL reset_u1_flags: got %b expected 00001",
               {b1.load, b1.shift_en, b1.word_done, b1.busy, b1.in_ready});
    else passes++;
    checks++;
    if (b1.d !== 4'h0) $display("FAIL reset_u1_d: got %h expected 0", b1.d);
    else passes++;
    checks++;
    if (b1.fifo_count !== 3'd0) $display("FAIL reset_u1_count: got %0d expected 0", b1.fifo_count);
    else passes++;
    checks++;
    if ({b3.load, b3.shift_en, b3.word_done, b3.busy, b3.in_ready} !== 5'b00001)
      $display("FAIL reset_u3_flags: got %b expected 00001",
               {b3.load, b3.shift_en, b3.word_done, b3.busy, b3.in_ready});
    else passes++;
    checks++;
    if (b3.d !== 4'h0) $display("FAIL reset_u3_d: got %h expected 0", b3.d);
    else passes++;
    checks++;
    if (b3.fifo_count !== 3'd0) $display("FAIL reset_u3_count: got %0d expected 0", b3.fifo_count);
    else passes++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_word();
    logic [3:0] exp_f [8];
    logic [3:0] exp_q [8];
    // flags are {load, shift_en, word_done, busy}
    exp_f = '{4'b0000, 4'b0000, 4'b1001, 4'b0101, 4'b0101, 4'b0101, 4'b0111, 4'b0000};
    exp_q = '{4'h0, 4'h0, 4'h0, 4'b1011, 4'b0101, 4'b0010, 4'b0001, 4'b0000};
    b1.in_valid = 1'b1; b1.in_data = 4'b1011;
    step();
    b1.in_valid = 1'b0;
    checks++;
    if (b1.fifo_count !== 3'd1) $display("FAIL single_count_c1: got %0d expected 1", b1.fifo_count);
    else passes++;
    for (int c = 1; c <= 7; c++) begin
      checks++;
      if ({b1.load, b1.shift_en, b1.word_done, b1.busy} !== exp_f[c])
        $display("FAIL single_flags_c%0d: got %b expected %b", c,
                 {b1.load, b1.shift_en, b1.word_done, b1.busy}, exp_f[c]);
      else passes++;
      if (c == 2) begin
        checks++;
        if (b1.d !== 4'b1011) $display("FAIL single_d: got %b expected 1011", b1.d);
        else passes++;
      end
      if (c >= 3) begin
        checks++;
        if (q1 !== exp_q[c]) $display("FAIL single_q_c%0d: got %b expected %b", c, q1, exp_q[c]);
        else passes++;
      end
      step();
    end
  endtask

  task automatic test_div3();
    logic [3:0] exp_f;
    int sh0;
    sh0 = shifts3;
    b3.in_valid = 1'b1; b3.in_data = 4'b0110;
    step();
    b3.in_valid = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      exp_f = {c == 2, (c == 5 || c == 8 || c == 11 || c == 14), c == 14, (c >= 2 && c <= 14)};
      checks++;
      if ({b3.load, b3.shift_en, b3.word_done, b3.busy} !== exp_f)
        $display("FAIL div3_flags_c%0d: got %b expected %b", c,
                 {b3.load, b3.shift_en, b3.word_done, b3.busy}, exp_f);
      else passes++;
      step();
    end
    checks++;
    if (shifts3 - sh0 != 4) $display("FAIL div3_shift_total: got %0d expected 4", shifts3 - sh0);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] w [3];
    logic [1:0] exp_f;
    int base, sh0, ov0;
    w = '{4'hA, 4'h5, 4'hF};
    base = loads1.size(); sh0 = shifts1; ov0 = overlaps1;
    b1.in_valid = 1'b1; b1.in_data = w[0];
    step();
    for (int c = 1; c <= 17; c++) begin
      if (c < 3) b1.in_data = w[c];
      else b1.in_valid = 1'b0;
      exp_f = {(c == 2 || c == 7 || c == 12), (c == 6 || c == 11 || c == 16)};
      checks++;
      if ({b1.load, b1.word_done} !== exp_f)
        $display("FAIL b2b_load_done_c%0d: got %b expected %b", c, {b1.load, b1.word_done}, exp_f);
      else passes++;
      step();
    end
    checks++;
    if (b1.busy !== 1'b0) $display("FAIL b2b_idle: got busy=%b expected 0", b1.busy);
    else passes++;
    checks++;
    if (loads1.size() - base != 3) $display("FAIL b2b_loads: got %0d expected 3", loads1.size() - base);
    else passes++;
    checks++;
    if (shifts1 - sh0 != 12) $display("FAIL b2b_shifts: got %0d expected 12", shifts1 - sh0);
    else passes++;
    checks++;
    if (overlaps1 != ov0) $display("FAIL b2b_overlap: got %0d expected 0", overlaps1 - ov0);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (loads1.size() <= base + i || loads1[base + i] !== w[i])
        $display("FAIL b2b_order_%0d: got %h expected %h", i,
                 (loads1.size() > base + i) ? loads1[base + i] : 4'hx, w[i]);
      else passes++;
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] w [6];
    logic exp_rdy;
    int exp_cnt, idx, base, sh0, ov0;
    w = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    idx = 0; base = loads3.size(); sh0 = shifts3; ov0 = overlaps3;
    for (int c = 0; c <= 82; c++) begin
      if (idx < 6) begin b3.in_valid = 1'b1; b3.in_data = w[idx]; end
      else b3.in_valid = 1'b0;
      if (c <= 16) begin
        exp_rdy = !(c >= 5 && c <= 14) && (c != 16);
        exp_cnt = (c == 0) ? 0 : (c <= 2) ? 1 : (c == 3) ? 2 : (c == 4 || c == 15) ? 3 : 4;
        checks++;
        if (b3.in_ready !== exp_rdy)
          $display("FAIL bp_ready_c%0d: got %b expected %b", c, b3.in_ready, exp_rdy);
        else passes++;
        checks++;
        if (b3.fifo_count !== 3'(exp_cnt))
          $display("FAIL bp_count_c%0d: got %0d expected %0d", c, b3.fifo_count, exp_cnt);
        else passes++;
      end
      if (b3.in_valid && b3.in_ready) idx++;
      step();
    end
    b3.in_valid = 1'b0;
    checks++;
    if (idx != 6) $display("FAIL bp_accepted: got %0d expected 6", idx);
    else passes++;
    checks++;
    if (b3.busy !== 1'b0) $display("FAIL bp_idle: got busy=%b expected 0", b3.busy);
    else passes++;
    checks++;
    if (loads3.size() - base != 6) $display("FAIL bp_loads: got %0d expected 6", loads3.size() - base);
    else passes++;
    checks++;
    if (shifts3 - sh0 != 24) $display("FAIL bp_shifts: got %0d expected 24", shifts3 - sh0);
    else passes++;
    checks++;
    if (overlaps3 != ov0) $display("FAIL bp_overlap: got %0d expected 0", overlaps3 - ov0);
    else passes++;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (loads3.size() <= base + i || loads3[base + i] !== w[i])
        $display("FAIL bp_order_%0d: got %h expected %h", i,
                 (loads3.size() > base + i) ? loads3[base + i] : 4'hx, w[i]);
      else passes++;
    end
  endtask

  task automatic test_push_pop_same();
    logic [3:0] w [5];
    int exp_cnt, idx, base;
    w = '{4'h3, 4'hC, 4'h7, 4'h8, 4'hE};
    idx = 0; base = loads1.size();
    for (int c = 0; c <= 28; c++) begin
      if ((c <= 3 || c == 6) && idx < 5) begin b1.in_valid = 1'b1; b1.in_data = w[idx]; end
      else b1.in_valid = 1'b0;
      if (c >= 1 && c <= 8) begin
        exp_cnt = (c <= 2) ? 1 : (c == 3) ? 2 : 3;
        checks++;
        if (b1.fifo_count !== 3'(exp_cnt))
          $display("FAIL pp_count_c%0d: got %0d expected %0d", c, b1.fifo_count, exp_cnt);
        else passes++;
      end
      if (c == 6) begin
        checks++;
        if ({b1.word_done, b1.in_ready} !== 2'b11)
          $display("FAIL pp_pop_push_c6: got %b expected 11", {b1.word_done, b1.in_ready});
        else passes++;
      end
      if (b1.in_valid && b1.in_ready) idx++;
      step();
    end
    b1.in_valid = 1'b0;
    checks++;
    if (loads1.size() - base != 5) $display("FAIL pp_loads: got %0d expected 5", loads1.size() - base);
    else passes++;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (loads1.size() <= base + i || loads1[base + i] !== w[i])
        $display("FAIL pp_order_%0d: got %h expected %h", i,
                 (loads1.size() > base + i) ? loads1[base + i] : 4'hx, w[i]);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] w [3];
    int dn0, sh0, ld0;
    w = '{4'h9, 4'h4, 4'h2};
    dn0 = dones1;
    for (int c = 0; c <= 4; c++) begin
      if (c < 3) begin b1.in_valid = 1'b1; b1.in_data = w[c]; end
      else b1.in_valid = 1'b0;
      if (c == 4) begin
        checks++;
        if ({b1.shift_en, b1.fifo_count} !== {1'b1, 3'd2})
          $display("FAIL rmid_pre: got shift=%b count=%0d expected shift=1 count=2",
                   b1.shift_en, b1.fifo_count);
        else passes++;
      end
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({b1.load, b1.shift_en, b1.word_done, b1.busy, b1.in_ready} !== 5'b00001)
      $display("FAIL rmid_flags: got %b expected 00001",
               {b1.load, b1.shift_en, b1.word_done, b1.busy, b1.in_ready});
    else passes++;
    checks++;
    if (b1.fifo_count !== 3'd0) $display("FAIL rmid_count: got %0d expected 0", b1.fifo_count);
    else passes++;
    sh0 = shifts1; ld0 = loads1.size();
    for (int c = 0; c < 8; c++) step();
    checks++;
    if (shifts1 != sh0 || loads1.size() != ld0 || dones1 != dn0)
      $display("FAIL rmid_quiet: got shifts=%0d loads=%0d dones=%0d expected 0 0 0",
               shifts1 - sh0, loads1.size() - ld0, dones1 - dn0);
    else passes++;
    b1.in_valid = 1'b1; b1.in_data = 4'h6;
    step();
    b1.in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) step();
    checks++;
    if (loads1.size() - ld0 != 1 || loads1[loads1.size() - 1] !== 4'h6)
      $display("FAIL rmid_new_load: got %0d loads last=%h expected 1 load of 6",
               loads1.size() - ld0, loads1[loads1.size() - 1]);
    else passes++;
    checks++;
    if (shifts1 - sh0 != 4 || dones1 - dn0 != 1)
      $display("FAIL rmid_new_run: got shifts=%0d dones=%0d expected 4 1",
               shifts1 - sh0, dones1 - dn0);
    else passes++;
  endtask

  initial begin
    b1.in_valid = 1'b0; b1.in_data = '0;
    b3.in_valid = 1'b0; b3.in_data = '0;
    test_reset();
    test_single_word();
    test_div3();
    test_back_to_back();
    test_backpressure();
    test_push_pop_same();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
